regfile_write_arbiter: RTL and testbench

- Owns the single write port of the register file and shares it between three requesters.
- Requesters, highest priority first: pipeline writeback (WB stage), exception/interrupt $k0 saves, and UART receive bytes.
- WB is never delayed. The $k0 save waits in a one-entry holding register. UART bytes wait in a small FIFO.
- Sits between the WB stage, the exception logic and the UART receiver on one side, and the register file write port on the other. Drives a stall signal to the ID hazard logic.

---
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB stage first, then a held $k0 save, then queued UART bytes.
// Define REGARB_STARVE_EN to enable the FIFO-head starvation counter that drives stall_req.
module regfile_write_arbiter #(
  parameter int         UART_FIFO_DEPTH = 4,
  parameter logic [4:0] UART_REG0       = 5'd2,
  parameter logic [4:0] UART_REG1       = 5'd3,
  parameter logic [4:0] K0_REG          = 5'd26,
  parameter int         STARVE_LIMIT    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wb_we,
  input  logic [4:0]                         wb_addr,
  input  logic [31:0]                        wb_data,
  input  logic                               exc_req,
  input  logic [31:0]                        exc_data,
  output logic                               exc_ack,
  input  logic                               uart_valid,
  input  logic                               uart_flag,
  input  logic [7:0]                         uart_data,
  output logic                               uart_ready,
  output logic                               rf_we,
  output logic [4:0]                         rf_addr,
  output logic [31:0]                        rf_data,
  output logic                               k0_pending,
  output logic [$clog2(UART_FIFO_DEPTH):0]   fifo_count,
  output logic                               stall_req
);

  localparam int PTR_W = $clog2(UART_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              hold_valid_q, hold_valid_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [8:0]        fifo_mem_q [UART_FIFO_DEPTH];

  logic       wb_busy;
  logic       fifo_empty;
  logic       fifo_full;
  logic       grant_k0;
  logic       pop;
  logic       push;
  logic [8:0] fifo_head;

  assign wb_busy    = wb_we && (wb_addr != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(UART_FIFO_DEPTH));
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  assign grant_k0 = !reset && !wb_busy && hold_valid_q;
  assign pop      = !reset && !wb_busy && !hold_valid_q && !fifo_empty;
  assign push     = !reset && uart_valid && !fifo_full;

  // A save may be accepted while the previous one is leaving through the port this cycle.
  assign exc_ack    = !reset && exc_req && (!hold_valid_q || grant_k0);
  assign k0_pending = exc_req || hold_valid_q;
  assign uart_ready = !fifo_full;
  assign fifo_count = count_q;

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (!reset) begin
      if (wb_busy) begin
        rf_we   = 1'b1;
        rf_addr = wb_addr;
        rf_data = wb_data;
      end else if (hold_valid_q) begin
        rf_we   = 1'b1;
        rf_addr = K0_REG;
        rf_data = hold_data_q;
      end else if (!fifo_empty) begin
        rf_we   = 1'b1;
        rf_addr = fifo_head[8] ? UART_REG1 : UART_REG0;
        rf_data = {24'h0, fifo_head[7:0]};
      end
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (exc_ack) begin
      hold_valid_d = 1'b1;
      hold_data_d  = exc_data;
    end else if (grant_k0) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {uart_flag, uart_data};
  end

`ifdef REGARB_STARVE_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != AGE_W'(STARVE_LIMIT)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

  assign stall_req = (age_q == AGE_W'(STARVE_LIMIT));
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register writes are queued as stimulus is
// driven and popped when the write port fires; priority, handshake and FIFO state checked inline.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exc_req;
  logic [31:0] exc_data;
  logic        exc_ack;
  logic        uart_valid;
  logic        uart_flag;
  logic [7:0]  uart_data;
  logic        uart_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        k0_pending;
  logic [2:0]  fifo_count;
  logic        stall_req;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .exc_req    (exc_req),
    .exc_data   (exc_data),
    .exc_ack    (exc_ack),
    .uart_valid (uart_valid),
    .uart_flag  (uart_flag),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .k0_pending (k0_pending),
    .fifo_count (fifo_count),
    .stall_req  (stall_req)
  );

`ifdef REGARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [36:0] sb_q [$];
  logic [8:0]  uart_q [$];
  logic [7:0]  fill_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we   = we;
    wb_addr = a;
    wb_data = d;
    if (we && a != 5'd0) sb_q.push_back({a, d});
  endtask

  task automatic uart(input logic v, input logic f, input logic [7:0] b);
    uart_valid = v;
    uart_flag  = f;
    uart_data  = b;
  endtask

  task automatic uart_push(input logic f, input logic [7:0] b);
    uart(1'b1, f, b);
    uart_q.push_back({f, b});
  endtask

  task automatic expect_uart();
    logic [8:0] e;
    e = uart_q.pop_front();
    sb_q.push_back({(e[8] ? 5'd3 : 5'd2), 24'h0, e[7:0]});
  endtask

  task automatic expect_k0(input logic [31:0] d);
    sb_q.push_back({5'd26, d});
  endtask

  task automatic sb_check();
    logic [36:0] e;
    if (!reset && rf_we) begin
      $display("write r%0d <= %h", rf_addr, rf_data);
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'(rf_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("rf_addr", 32'(rf_addr), 32'(e[36:32]));
        chk("rf_data", rf_data, e[31:0]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    uart(1'b0, 1'b0, 8'h0);
    exc_req  = 1'b0;
    exc_data = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    tick();
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_uart_ready", 32'(uart_ready), 32'd1);
    chk("rst_rf_we",      32'(rf_we),      32'd0);
    chk("rst_exc_ack",    32'(exc_ack),    32'd0);
    chk("rst_k0_pending", 32'(k0_pending), 32'd0);
    chk("rst_stall",      32'(stall_req),  32'd0);
    adv();
    reset = 1'b0;

    // Idle path: WB passes through in the same cycle; $0 writes are dropped
    wb(1'b1, 5'd8, 32'h1234_5678);
    tick();
    chk("wb_rf_we", 32'(rf_we), 32'd1);
    adv();
    wb(1'b1, 5'd0, 32'hDEAD_DEAD);
    tick();
    chk("wb_zero_rf_we", 32'(rf_we), 32'd0);
    adv();

    // Exception save while WB is busy for 3 cycles
    wb(1'b1, 5'd9, 32'h0000_0009);
    exc_req  = 1'b1;
    exc_data = 32'h0040_0010;
    tick();
    chk("exc_ack_pulse", 32'(exc_ack), 32'd1);
    chk("k0_pend_req",   32'(k0_pending), 32'd1);
    adv();
    exc_req = 1'b0;
    wb(1'b1, 5'd10, 32'h0000_000A);
    tick();
    chk("exc_ack_low",   32'(exc_ack), 32'd0);
    chk("k0_pend_held1", 32'(k0_pending), 32'd1);
    adv();
    wb(1'b1, 5'd11, 32'h0000_000B);
    tick();
    chk("k0_pend_held2", 32'(k0_pending), 32'd1);
    adv();
    wb(1'b0, 5'd0, 32'h0);
    expect_k0(32'h0040_0010);
    tick();
    chk("k0_write_we",   32'(rf_we), 32'd1);
    chk("k0_pend_drain", 32'(k0_pending), 32'd1);
    adv();
    tick();
    chk("k0_pend_clear", 32'(k0_pending), 32'd0);
    chk("k0_idle_we",    32'(rf_we), 32'd0);
    adv();

    // FIFO fill with WB continuously busy
    for (int i = 0; i < 4; i++) begin
      wb(1'b1, 5'(12 + i), 32'(32'h100 + i));
      uart_push(i[0], fill_b[i]);
      tick();
      chk("fill_ready", 32'(uart_ready), 32'd1);
      chk("fill_count", 32'(fifo_count), 32'(i));
      adv();
    end
    wb(1'b1, 5'd16, 32'h0000_0116);
    uart(1'b1, 1'b0, 8'hEE);
    tick();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(uart_ready), 32'd0);
    adv();
    wb(1'b1, 5'd17, 32'h0000_0117);
    uart(1'b0, 1'b0, 8'h0);
    tick();
    chk("full_no_push", 32'(fifo_count), 32'd4);
    adv();

    // FIFO drain once WB is released
    wb(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      expect_uart();
      tick();
      chk("drain_count", 32'(fifo_count), 32'(4 - i));
      adv();
    end
    tick();
    chk("drained_count", 32'(fifo_count), 32'd0);
    chk("drained_we",    32'(rf_we), 32'd0);
    adv();

    // Contention: WB, held $k0 and FIFO head all present
    wb(1'b1, 5'd20, 32'h0000_00A0);
    exc_req  = 1'b1;
    exc_data = 32'hDEAD_BEEF;
    uart_push(1'b0, 8'h5A);
    tick();
    chk("cont_exc_ack", 32'(exc_ack), 32'd1);
    adv();
    exc_req = 1'b0;
    wb(1'b1, 5'd26, 32'h1111_1111);
    uart_push(1'b1, 8'h6B);
    tick();
    chk("cont_count1", 32'(fifo_count), 32'd1);
    chk("cont_k0_pend", 32'(k0_pending), 32'd1);
    adv();
    wb(1'b1, 5'd21, 32'h0000_00A2);
    uart(1'b0, 1'b0, 8'h0);
    tick();
    chk("cont_count2", 32'(fifo_count), 32'd2);
    adv();
    wb(1'b0, 5'd0, 32'h0);
    expect_k0(32'hDEAD_BEEF);
    tick();
    chk("cont_k0_addr", 32'(rf_addr), 32'd26);
    adv();
    uart_push(1'b0, 8'h7C);
    expect_uart();
    tick();
    chk("cont_pre_pushpop", 32'(fifo_count), 32'd2);
    adv();
    uart(1'b0, 1'b0, 8'h0);
    expect_uart();
    tick();
    chk("pushpop_count", 32'(fifo_count), 32'd2);
    adv();
    expect_uart();
    tick();
    chk("cont_count_last", 32'(fifo_count), 32'd1);
    adv();
    tick();
    chk("cont_empty", 32'(fifo_count), 32'd0);
    adv();

    // Starvation: head held off by WB for 20 cycles
    wb(1'b1, 5'd4, 32'h0000_0004);
    uart_push(1'b1, 8'h99);
    tick();
    adv();
    uart(1'b0, 1'b0, 8'h0);
    for (int k = 0; k < 20; k++) begin
      wb(1'b1, 5'(k + 1), 32'(32'h200 + k));
      tick();
      chk("starve_stall", 32'(stall_req), 32'(STARVE_ON && (k >= 16)));
      adv();
    end
    wb(1'b0, 5'd0, 32'h0);
    expect_uart();
    tick();
    chk("starve_pop_cycle", 32'(stall_req), 32'(STARVE_ON));
    adv();
    tick();
    chk("starve_after_pop", 32'(stall_req), 32'd0);
    adv();

    // Reset mid-traffic with 3 bytes queued and a $k0 save held
    wb(1'b1, 5'd5, 32'h0000_0005);
    exc_req  = 1'b1;
    exc_data = 32'hCAFE_0001;
    uart_push(1'b0, 8'h11);
    tick();
    chk("mid_exc_ack", 32'(exc_ack), 32'd1);
    adv();
    exc_req = 1'b0;
    wb(1'b1, 5'd6, 32'h0000_0006);
    uart_push(1'b1, 8'h22);
    tick();
    adv();
    wb(1'b1, 5'd7, 32'h0000_0007);
    uart_push(1'b0, 8'h33);
    tick();
    chk("mid_count", 32'(fifo_count), 32'd2);
    adv();
    uart(1'b0, 1'b0, 8'h0);
    wb_we   = 1'b1;
    wb_addr = 5'd7;
    wb_data = 32'h0000_0077;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rf_we", 32'(rf_we),      32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(uart_ready), 32'd1);
    chk("mid_rst_ack",   32'(exc_ack),    32'd0);
    uart_q.delete();
    tick();
    adv();
    reset = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("post_rst_k0_pend", 32'(k0_pending), 32'd0);
    chk("post_rst_rf_we",   32'(rf_we),      32'd0);
    chk("post_rst_count",   32'(fifo_count), 32'd0);
    adv();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
